adc_mp_sched: RTL and testbench

//  Shares one 32-bit `adc` ripple adder between two requesters and sequences

---
 rtl/adc_mp_sched_if.sv | 47 ++++
 rtl/adc_mp_sched.sv | 149 ++++++++++++++
 tb/tb_adc_mp_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_mp_sched_if.sv
// Request/result bundle for the shared multi-precision adder scheduler.
// Two requester ports and one result port; master drives requests.
interface adc_mp_sched_if #(
  parameter int WORDS = 2
);
  localparam int N = 32 * WORDS;

  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_sub;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_sum;
  logic         res_cout;
  logic         res_ovf;
  logic         res_id;
  logic         busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    output res_ready,
    input  res_valid, res_sum, res_cout, res_ovf, res_id,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    input  res_ready,
    output res_valid, res_sum, res_cout, res_ovf, res_id,
    output busy
  );
endinterface

// File: rtl/adc_mp_sched.sv
// Round-robin scheduler sharing one 32-bit adc between two requesters.
// Runs WORDS-beat add/subtract with beat-to-beat carry chaining.
module adc_mp_sched #(
  parameter int WORDS = 2
) (
  input  logic         clk,
  input  logic         rst,
  adc_mp_sched_if.slave bus
);
  localparam int N  = 32 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic          last_grant;
  logic          gnt0;
  logic          gnt1;
  logic          hs;

  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  sum_r;
  logic [N-1:0]  sum_nx;
  logic          sub_r;
  logic          id_r;
  logic          carry_r;
  logic [KW-1:0] k;
  logic          last_beat;

  logic [31:0]   beat_a;
  logic [31:0]   beat_b;
  logic [31:0]   beat_s;
  logic          beat_cin;
  logic          beat_c;

  logic [N-1:0]  res_sum_r;
  logic          res_cout_r;
  logic          res_ovf_r;
  logic          res_id_r;

  // Arbitration: lone valid wins, contention goes to the non-last grantee.
  always_comb begin
    gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    hs   = (state == IDLE) & ~rst & (gnt0 | gnt1);
  end

  // One adder beat; carry-in is the sub bit on beat 0, else chained.
  always_comb begin
    last_beat = (k == KW'(WORDS - 1));
    beat_cin  = (k == '0) ? sub_r : carry_r;
    beat_a    = a_r[32*k +: 32];
    beat_b    = b_r[32*k +: 32];
    {beat_c, beat_s} = {1'b0, beat_a} + {1'b0, beat_b}
                     + {32'd0, beat_cin};
    sum_nx    = sum_r;
    sum_nx[32*k +: 32] = beat_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hs)            state_nx = EXEC;
      EXEC: if (last_beat)     state_nx = DONE;
      DONE: if (bus.res_ready) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    bus.req0_ready = (state == IDLE) & ~rst & gnt0;
    bus.req1_ready = (state == IDLE) & ~rst & gnt1;
    bus.res_valid  = (state == DONE);
    bus.busy       = (state != IDLE);
  end

  // Operand capture, beat sequencing and result latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      sub_r      <= 1'b0;
      id_r       <= 1'b0;
      carry_r    <= 1'b0;
      k          <= '0;
      res_sum_r  <= '0;
      res_cout_r <= 1'b0;
      res_ovf_r  <= 1'b0;
      res_id_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            last_grant <= gnt1;
            id_r       <= gnt1;
            k          <= '0;
            if (gnt1) begin
              a_r   <= bus.req1_a;
              b_r   <= bus.req1_b ^ {N{bus.req1_sub}};
              sub_r <= bus.req1_sub;
            end else begin
              a_r   <= bus.req0_a;
              b_r   <= bus.req0_b ^ {N{bus.req0_sub}};
              sub_r <= bus.req0_sub;
            end
          end
        end
        EXEC: begin
          sum_r   <= sum_nx;
          carry_r <= beat_c;
          if (last_beat) begin
            k          <= '0;
            res_sum_r  <= sum_nx;
            res_cout_r <= beat_c;
            res_ovf_r  <= (a_r[N-1] == b_r[N-1])
                        & (sum_nx[N-1] != a_r[N-1]);
            res_id_r   <= id_r;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.res_sum  = res_sum_r;
  assign bus.res_cout = res_cout_r;
  assign bus.res_ovf  = res_ovf_r;
  assign bus.res_id   = res_id_r;
endmodule

// File: tb/tb_adc_mp_sched.sv
// Directed bench for adc_mp_sched with WORDS=2.
// Inputs change on falling edges; outputs sampled on falling edges.
module tb_adc_mp_sched;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  adc_mp_sched_if #(.WORDS(2)) bus ();

  adc_mp_sched #(.WORDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    chk("rst_rdy1", bus.req1_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input int r, input logic [63:0] a,
                       input logic [63:0] b, input logic sub);
    int   n;
    logic rdy;
    @(negedge clk);
    if (r == 0) begin
      bus.req0_a = a; bus.req0_b = b;
      bus.req0_sub = sub; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b;
      bus.req1_sub = sub; bus.req1_valid = 1'b1;
    end
    #1;
    n   = 0;
    rdy = (r == 0) ? bus.req0_ready : bus.req1_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
      rdy = (r == 0) ? bus.req0_ready : bus.req1_ready;
    end
    chk("grant_wait", rdy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (r == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    #1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("drop_valid", bus.res_valid, 1'b0);
  endtask

  task automatic op(input string tag, input int r, input logic [63:0] a,
                    input logic [63:0] b, input logic sub,
                    input logic [63:0] s, input logic co, input logic ov);
    int lat;
    issue(r, a, b, sub);
    wait_res(lat);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_sum"}, bus.res_sum, s);
    chk({tag, "_cout"}, bus.res_cout, co);
    chk({tag, "_ovf"}, bus.res_ovf, ov);
    chk({tag, "_id"}, bus.res_id, r[0]);
    consume();
  endtask

  initial begin
    int   lat;
    int   dbl;
    int   gq[$];
    int   iq[$];
    int   bad_sum;
    logic [63:0] hs_sum;
    logic hs_co, hs_ov, hs_id;
    int   unstable, bsy_bad, rdy_bad, stray;

    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.res_ready = 1'b0;

    do_reset();
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_valid", bus.res_valid, 1'b0);
    chk("reset_sum", bus.res_sum, 64'd0);
    chk("reset_cout", bus.res_cout, 1'b0);
    chk("reset_ovf", bus.res_ovf, 1'b0);
    chk("reset_id", bus.res_id, 1'b0);

    op("add_carry", 0, 64'h00000000_FFFFFFFF, 64'd1, 1'b0,
       64'h00000001_00000000, 1'b0, 1'b0);
    op("sub_0m1", 0, 64'd0, 64'd1, 1'b1,
       64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0);
    op("sub_ovf", 1, 64'h80000000_00000000, 64'd1, 1'b1,
       64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1);
    op("add_ones", 0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0,
       64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0);
    op("add_ovf", 1, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0,
       64'h80000000_00000000, 1'b0, 1'b1);

    // Round-robin under constant contention.
    bus.req0_a = 64'd1;  bus.req0_b = 64'd2; bus.req0_sub = 1'b0;
    bus.req1_a = 64'd10; bus.req1_b = 64'd3; bus.req1_sub = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    do_reset();
    bus.res_ready = 1'b1;
    dbl = 0;
    bad_sum = 0;
    for (int i = 0; i < 18; i++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) dbl++;
      if (bus.req0_ready) gq.push_back(0);
      if (bus.req1_ready) gq.push_back(1);
      if (bus.res_valid) begin
        iq.push_back(int'(bus.res_id));
        if (bus.res_sum !== (bus.res_id ? 64'd7 : 64'd3)) bad_sum++;
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b0;
    chk("rr_double_ready", dbl, 0);
    chk("rr_sum_bad", bad_sum, 0);
    chk("rr_grant_cnt_ge4", gq.size() >= 4, 1'b1);
    chk("rr_id_cnt_ge4", iq.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), (i < gq.size()) ? gq[i] : -1, i % 2);
      chk($sformatf("rr_id%0d", i), (i < iq.size()) ? iq[i] : -1, i % 2);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Backpressure with a pending request on port 1.
    issue(0, 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 1'b0);
    bus.req1_a = 64'd100; bus.req1_b = 64'd58;
    bus.req1_sub = 1'b1;  bus.req1_valid = 1'b1;
    wait_res(lat);
    chk("bp_lat", lat, 3);
    chk("bp_sum", bus.res_sum, 64'h23456789_ABCDF001);
    hs_sum = bus.res_sum; hs_co = bus.res_cout;
    hs_ov = bus.res_ovf;  hs_id = bus.res_id;
    unstable = 0; bsy_bad = 0; rdy_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (bus.res_sum !== hs_sum || bus.res_cout !== hs_co ||
          bus.res_ovf !== hs_ov || bus.res_id !== hs_id ||
          bus.res_valid !== 1'b1) unstable++;
      if (bus.busy !== 1'b1) bsy_bad++;
      if (bus.req0_ready || bus.req1_ready) rdy_bad++;
    end
    chk("bp_unstable", unstable, 0);
    chk("bp_busy", bsy_bad, 0);
    chk("bp_ready", rdy_bad, 0);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("bp_release_valid", bus.res_valid, 1'b0);
    chk("bp_release_busy", bus.busy, 1'b0);
    chk("bp_pending_rdy", bus.req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    wait_res(lat);
    chk("bp2_lat", lat, 3);
    chk("bp2_id", bus.res_id, 1'b1);
    chk("bp2_sum", bus.res_sum, 64'd42);
    chk("bp2_cout", bus.res_cout, 1'b1);
    consume();

    // Reset mid-EXEC; port 0 last granted, reset must restore port 0 priority.
    issue(0, 64'h00000000_FFFFFFFF, 64'd5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_valid", bus.res_valid, 1'b0);
    chk("mid_rst_sum", bus.res_sum, 64'd0);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (bus.res_valid || bus.busy) stray++;
    end
    chk("mid_rst_stray", stray, 0);
    bus.req0_a = 64'd7; bus.req0_b = 64'd8; bus.req0_sub = 1'b0;
    bus.req1_a = 64'd9; bus.req1_b = 64'd1; bus.req1_sub = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    chk("post_rst_rdy0", bus.req0_ready, 1'b1);
    chk("post_rst_rdy1", bus.req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_res(lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_id", bus.res_id, 1'b0);
    chk("post_rst_sum", bus.res_sum, 64'd15);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
